ghost_motion: RTL and testbench
===============================

GHOST_MOTION -- requirements
Module: ghost_motion

Interface
REQ-001 Parameter START_X, default 10'd320, reset X position in pixels.
REQ-002 Parameter START_Y, default 10'd240, reset Y position in pixels.
REQ-003 Parameter X_MAX, default 10'd639, rightmost legal X; X wraps between 0 and X_MAX.
REQ-004 Parameter Y_MAX, default 10'd479, bottom legal Y; Y saturates at 0 and Y_MAX.
REQ-005 Parameter TICK_DIV, default 4'd2, number of frame_tick pulses per move step (range 1-15).
REQ-006 Clk  input  1  single system clock; all state on posedge Clk.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 frame_tick  input  1  one-cycle pulse per video frame.
REQ-009 dir_code  input  8  direction keycode: 0x04 left, 0x07 right, 0x16 down, 0x1A up.
REQ-010 dir_valid  input  1  dir_code is sampled on any cycle where this is high.
REQ-011 blocked  input  4  wall flags for the current tile, bit order {up, down, right, left}; 1 = blocked.
REQ-012 pos_x  output  10  current X position.
REQ-013 pos_y  output  10  current Y position.
REQ-014 cur_dir  output  2  committed direction: 0 left, 1 right, 2 down, 3 up.
REQ-015 moving  output  1  high while in state MOVE.

Function
REQ-016 Keycode decode SHALL be combinational; any code other than the four listed SHALL be ignored, leaving the pending direction unchanged.
REQ-017 The pending-direction register SHALL load the decoded direction on the cycle after dir_valid is high with a legal code; the last legal code wins.
REQ-018 The divider counter SHALL increment on each frame_tick; on the pulse that brings it to TICK_DIV, it SHALL clear to 0 and raise a one-cycle move_evt.
REQ-019 FSM states SHALL be IDLE, MOVE and STALLED; IDLE exits only once a legal code has been captured.
REQ-020 On move_evt, if blocked[pending] = 0: cur_dir <= pending and position steps 1 pixel in pending; state <= MOVE.
REQ-021 Otherwise, on move_evt, if blocked[cur_dir] = 0 and state is not IDLE: position steps 1 pixel in cur_dir; state <= MOVE.
REQ-022 Otherwise, on move_evt: no position change and state <= STALLED (IDLE stays IDLE).
REQ-023 In STALLED, moving SHALL be 0; the next move_evt with a free direction SHALL resume per REQ-020/021.
REQ-024 Position SHALL update exactly one cycle after move_evt, and never on any other cycle.
REQ-025 Horizontal wrap: left at X=0 gives X_MAX; right at X=X_MAX gives 0.
REQ-026 Vertical saturation: up at Y=0 and down at Y=Y_MAX SHALL leave Y unchanged but still count as MOVE.
REQ-027 Simultaneous dir_valid and move_evt: move_evt SHALL use the previously held pending value; the new code takes effect at the next move_evt.
REQ-028 Arithmetic SHALL be 10-bit unsigned, with no intermediate overflow beyond the wrap and saturate rules.

Reset
REQ-029 While Reset is high: pos_x = START_X, pos_y = START_Y, cur_dir = 0, pending = 0, divider = 0, state = IDLE, moving = 0.
REQ-030 Reset asserted mid-step SHALL override any concurrent move_evt or dir_valid in the same cycle.

Structure
REQ-031 Shared package dir_pkg SHALL hold the dir_t enum (LEFT, RIGHT, DOWN, UP), the four keycode constants and the FSM state enum.
REQ-032 The keycode decode SHALL be one sub-module, dir_decode (8-bit code in, dir_t plus legal flag out), reusable by the keyboard path.

Verification
REQ-033 Reset, then no dir_valid for 10 frame_ticks -> pos stays (320,240), moving=0, state IDLE.
REQ-034 dir_code=0x07 valid, blocked=0, TICK_DIV=2, 6 frame_ticks -> pos_x=323, cur_dir=1, moving=1.
REQ-035 X=639 moving right, one move_evt -> pos_x=0; X=0 moving left -> pos_x=639.
REQ-036 Moving left, pending up with blocked[3]=1 -> continues left; set blocked[0]=1 -> STALLED, moving=0; clear blocked[3] -> next step goes up, cur_dir=3.
REQ-037 dir_code=0x55 valid while moving down -> pending unchanged, motion continues down.
REQ-038 Reset pulsed in the same cycle as move_evt at pos (100,50) -> next cycle pos=(320,240), state IDLE.

Source files
------------

// File: rtl/dir_pkg.sv
// Shared direction, keycode and motion-state definitions for the ghost
// movement path and the keyboard path.
package dir_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    UP    = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    STALLED = 2'd2
  } state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_UP    = 8'h1A;

endpackage

// File: rtl/dir_decode.sv
// Combinational keycode-to-direction decoder; unknown codes drop the legal flag.
module dir_decode
  import dir_pkg::*;
(
  input  logic [7:0] code,
  output dir_t       dir,
  output logic       legal
);

  always_comb begin
    dir   = LEFT;
    legal = 1'b0;
    case (code)
      KEY_LEFT:  begin dir = LEFT;  legal = 1'b1; end
      KEY_RIGHT: begin dir = RIGHT; legal = 1'b1; end
      KEY_DOWN:  begin dir = DOWN;  legal = 1'b1; end
      KEY_UP:    begin dir = UP;    legal = 1'b1; end
      default:   begin dir = LEFT;  legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/ghost_motion.sv
// Ghost sprite mover: frame-divided step timing, pending/committed direction,
// wall checks, horizontal wrap and vertical saturation.
module ghost_motion
  import dir_pkg::*;
#(
  parameter logic [9:0] START_X  = 10'd320,
  parameter logic [9:0] START_Y  = 10'd240,
  parameter logic [9:0] X_MAX    = 10'd639,
  parameter logic [9:0] Y_MAX    = 10'd479,
  parameter logic [3:0] TICK_DIV = 4'd2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] dir_code,
  input  logic       dir_valid,
  input  logic [3:0] blocked,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] cur_dir,
  output logic       moving
);

  dir_t       dec_dir_s;
  logic       dec_legal_s;
  dir_t       pending_r;
  logic       have_dir_r;
  logic [3:0] div_r;
  logic       move_evt_r;
  state_t     state_r;
  dir_t       cur_dir_r;
  logic [9:0] pos_x_r;
  logic [9:0] pos_y_r;

  dir_t       step_dir_s;
  logic       step_s;
  dir_t       cur_nxt_s;
  state_t     state_nxt_s;
  logic [9:0] next_x_s;
  logic [9:0] next_y_s;

  dir_decode u_dir_decode (
    .code  (dir_code),
    .dir   (dec_dir_s),
    .legal (dec_legal_s)
  );

  // Pending direction wins if free; otherwise keep going the committed way.
  always_comb begin
    step_dir_s  = cur_dir_r;
    step_s      = 1'b0;
    cur_nxt_s   = cur_dir_r;
    state_nxt_s = state_r;
    if (have_dir_r && !blocked[pending_r]) begin
      step_dir_s  = pending_r;
      step_s      = 1'b1;
      cur_nxt_s   = pending_r;
      state_nxt_s = MOVE;
    end else if ((state_r != IDLE) && !blocked[cur_dir_r]) begin
      step_s      = 1'b1;
      state_nxt_s = MOVE;
    end else if (state_r != IDLE) begin
      state_nxt_s = STALLED;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // X wraps around the screen edge, Y sticks at the top and bottom rows.
  always_comb begin
    next_x_s = pos_x_r;
    next_y_s = pos_y_r;
    case (step_dir_s)
      LEFT:    next_x_s = (pos_x_r == 10'd0)  ? X_MAX   : pos_x_r - 10'd1;
      RIGHT:   next_x_s = (pos_x_r >= X_MAX)  ? 10'd0   : pos_x_r + 10'd1;
      DOWN:    next_y_s = (pos_y_r >= Y_MAX)  ? pos_y_r : pos_y_r + 10'd1;
      UP:      next_y_s = (pos_y_r == 10'd0)  ? pos_y_r : pos_y_r - 10'd1;
      default: begin
        next_x_s = pos_x_r;
        next_y_s = pos_y_r;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_r  <= LEFT;
      have_dir_r <= 1'b0;
      div_r      <= 4'd0;
      move_evt_r <= 1'b0;
      state_r    <= IDLE;
      cur_dir_r  <= LEFT;
      pos_x_r    <= START_X;
      pos_y_r    <= START_Y;
    end else begin
      if (dir_valid && dec_legal_s) begin
        pending_r  <= dec_dir_s;
        have_dir_r <= 1'b1;
      end
      move_evt_r <= 1'b0;
      if (frame_tick) begin
        if (div_r >= (TICK_DIV - 4'd1)) begin
          div_r      <= 4'd0;
          move_evt_r <= 1'b1;
        end else begin
          div_r <= div_r + 4'd1;
        end
      end
      // move_evt uses the pending value held before any same-cycle key capture.
      if (move_evt_r) begin
        state_r   <= state_nxt_s;
        cur_dir_r <= cur_nxt_s;
        if (step_s) begin
          pos_x_r <= next_x_s;
          pos_y_r <= next_y_s;
        end
      end
    end
  end

  assign pos_x   = pos_x_r;
  assign pos_y   = pos_y_r;
  assign cur_dir = cur_dir_r;
  assign moving  = (state_r == MOVE);

endmodule

// File: tb/tb_ghost_motion.sv
// Directed bench for ghost_motion: expectations queued before each step and
// checked against the outputs once the step has settled.
module tb_ghost_motion;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] dir_code;
  logic       dir_valid;
  logic [3:0] blocked;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [1:0] cur_dir;
  logic       moving;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] d;
    logic       m;
  } exp_t;

  exp_t exp_q[$];

  ghost_motion dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .dir_code   (dir_code),
    .dir_valid  (dir_valid),
    .blocked    (blocked),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .cur_dir    (cur_dir),
    .moving     (moving)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic push_exp(input string tag, input logic [9:0] x, input logic [9:0] y,
                          input logic [1:0] d, input logic m);
    exp_t e;
    e.tag = tag; e.x = x; e.y = y; e.d = d; e.m = m;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [22:0] obs;
    logic [22:0] expv;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed empty queue, expected an entry");
    end else begin
      e    = exp_q.pop_front();
      obs  = {pos_x, pos_y, cur_dir, moving};
      expv = {e.x, e.y, e.d, e.m};
      assert (obs === expv) else begin
        mismatched++;
        $error("FAIL %s: observed x=%0d y=%0d dir=%0d mv=%0b expected x=%0d y=%0d dir=%0d mv=%0b",
               e.tag, pos_x, pos_y, cur_dir, moving, e.x, e.y, e.d, e.m);
      end
    end
  endtask

  task automatic do_tick();
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  task automatic move_step();
    do_tick();
    do_tick();
  endtask

  task automatic send_key(input logic [7:0] code);
    @(negedge Clk) begin dir_valid = 1'b1; dir_code = code; end
    @(negedge Clk) dir_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; dir_code = 8'h00; dir_valid = 1'b0; blocked = 4'b0000;
    push_exp("reset_hold", 10'd320, 10'd240, 2'd0, 1'b0);
    repeat (3) @(negedge Clk);
    pop_check();
    Reset = 1'b0;

    // No key yet: ten ticks leave the ghost parked.
    push_exp("idle_no_key", 10'd320, 10'd240, 2'd0, 1'b0);
    repeat (10) do_tick();
    pop_check();

    send_key(8'h07);
    push_exp("right_6_ticks", 10'd323, 10'd240, 2'd1, 1'b1);
    repeat (6) do_tick();
    pop_check();

    push_exp("right_to_xmax", 10'd639, 10'd240, 2'd1, 1'b1);
    for (int i = 0; i < 316; i++) move_step();
    pop_check();

    push_exp("wrap_right", 10'd0, 10'd240, 2'd1, 1'b1);
    move_step();
    pop_check();

    send_key(8'h04);
    push_exp("wrap_left", 10'd639, 10'd240, 2'd0, 1'b1);
    move_step();
    pop_check();

    push_exp("left_step", 10'd638, 10'd240, 2'd0, 1'b1);
    move_step();
    pop_check();

    // Pending up is walled: keep going left, then stall, then turn up.
    blocked = 4'b1000;
    send_key(8'h1A);
    push_exp("up_blocked_cont_left", 10'd637, 10'd240, 2'd0, 1'b1);
    move_step();
    pop_check();

    blocked = 4'b1001;
    push_exp("stalled", 10'd637, 10'd240, 2'd0, 1'b0);
    move_step();
    pop_check();

    blocked = 4'b0001;
    push_exp("resume_up", 10'd637, 10'd239, 2'd3, 1'b1);
    move_step();
    pop_check();

    blocked = 4'b0000;
    send_key(8'h16);
    push_exp("turn_down", 10'd637, 10'd240, 2'd2, 1'b1);
    move_step();
    pop_check();

    send_key(8'h55);
    push_exp("bad_code_ignored", 10'd637, 10'd241, 2'd2, 1'b1);
    move_step();
    pop_check();

    push_exp("down_to_ymax", 10'd637, 10'd479, 2'd2, 1'b1);
    for (int i = 0; i < 238; i++) move_step();
    pop_check();

    push_exp("down_saturate", 10'd637, 10'd479, 2'd2, 1'b1);
    move_step();
    pop_check();

    send_key(8'h1A);
    push_exp("up_to_zero", 10'd637, 10'd0, 2'd3, 1'b1);
    for (int i = 0; i < 479; i++) move_step();
    pop_check();

    push_exp("up_saturate", 10'd637, 10'd0, 2'd3, 1'b1);
    move_step();
    pop_check();

    // Key arrives in the same cycle as the move event: old pending is used.
    do_tick();
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) begin frame_tick = 1'b0; dir_valid = 1'b1; dir_code = 8'h07; end
    @(negedge Clk) dir_valid = 1'b0;
    push_exp("same_cycle_key_old_dir", 10'd637, 10'd0, 2'd3, 1'b1);
    @(negedge Clk);
    pop_check();

    push_exp("same_cycle_key_next", 10'd638, 10'd0, 2'd1, 1'b1);
    move_step();
    pop_check();

    // Reset coincides with the move event and must win.
    do_tick();
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) begin frame_tick = 1'b0; Reset = 1'b1; end
    push_exp("reset_over_move", 10'd320, 10'd240, 2'd0, 1'b0);
    @(negedge Clk);
    pop_check();
    Reset = 1'b0;

    push_exp("idle_after_reset", 10'd320, 10'd240, 2'd0, 1'b0);
    move_step();
    pop_check();

    send_key(8'h04);
    push_exp("left_after_reset", 10'd319, 10'd240, 2'd0, 1'b1);
    move_step();
    pop_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
